fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 173 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the instruction-memory address,
// hands words to the decoder and resolves branches, calls and returns.
module fetch_sequencer #(
    parameter logic [11:0] RESET_PC    = 12'h000,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [11:0] pc_out,
    input  logic [18:0] mem_instr,
    output logic [18:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        flag_z,
    input  logic        flag_c,
    input  logic        flags_valid,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [3:0]  depth
);

    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [3:0] FULL = 4'(STACK_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BR_WAIT,
        S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [3:0]  depth_q, depth_d;
    logic [1:0]  code_q, code_d;
    logic [1:0]  cond_q, cond_d;
    logic [7:0]  off_q, off_d;
    logic        push;
    logic        br_taken;
    logic [11:0] stk_q [0:STACK_DEPTH-1];

    logic        handoff;
    logic        is_br, is_jmp, is_jsb, is_ret;
    logic        stk_full, stk_empty;
    logic [11:0] pc_inc;
    logic [11:0] br_off;

    assign handoff   = (state_q == S_ISSUE) & instr_ready;
    assign is_br     = mem_instr[18:16] == 3'b101;
    assign is_jmp    = mem_instr[18:14] == 5'b11100;
    assign is_jsb    = mem_instr[18:14] == 5'b11101;
    assign is_ret    = mem_instr[18:13] == 6'b111100;
    assign stk_full  = depth_q == FULL;
    assign stk_empty = depth_q == 4'd0;
    assign pc_inc    = pc_q + 12'd1;
    assign br_off    = {{4{off_q[7]}}, off_q};

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            depth_q <= 4'd0;
            code_q  <= 2'b00;
            cond_q  <= 2'b00;
            off_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            code_q  <= code_d;
            cond_q  <= cond_d;
            off_q   <= off_d;
        end
    end

    // Return stack storage; contents are irrelevant after reset
    always_ff @(posedge clk) begin
        if (push) begin
            stk_q[AW'(depth_q)] <= pc_inc;
        end
    end

    // Branch condition from the held branch word and current flags
    always_comb begin
        br_taken = 1'b0;
        unique case (cond_q)
            2'b00: br_taken = flag_z;
            2'b01: br_taken = !flag_z;
            2'b10: br_taken = flag_c;
            2'b11: br_taken = !flag_c;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (handoff) begin
                    if (is_br) state_d = S_BR_WAIT;
                    else if (is_jsb && stk_full) state_d = S_FAULT;
                    else if (is_ret && stk_empty) state_d = S_FAULT;
                end
            end
            S_BR_WAIT: begin
                if (flags_valid) state_d = S_ISSUE;
            end
            S_FAULT: state_d = S_FAULT;
        endcase
    end

    // Datapath next values: pc, stack, held branch and fault code
    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        code_d  = code_q;
        cond_d  = cond_q;
        off_d   = off_q;
        push    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) pc_d = RESET_PC;
            end
            S_ISSUE: begin
                if (handoff) begin
                    if (is_br) begin
                        cond_d = mem_instr[15:14];
                        off_d  = mem_instr[7:0];
                    end else if (is_jmp) begin
                        pc_d = mem_instr[11:0];
                    end else if (is_jsb) begin
                        if (!stk_full) begin
                            push    = 1'b1;
                            depth_d = depth_q + 4'd1;
                            pc_d    = mem_instr[11:0];
                        end else begin
                            code_d = 2'b01;
                        end
                    end else if (is_ret) begin
                        if (!stk_empty) begin
                            pc_d    = stk_q[AW'(depth_q - 4'd1)];
                            depth_d = depth_q - 4'd1;
                        end else begin
                            code_d = 2'b10;
                        end
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            S_BR_WAIT: begin
                if (flags_valid) pc_d = br_taken ? pc_inc + br_off : pc_inc;
            end
            S_FAULT: pc_d = pc_q;
        endcase
    end

    // Outputs decoded from state and registers
    always_comb begin
        pc_out      = pc_q;
        instr_out   = mem_instr;
        instr_valid = state_q == S_ISSUE;
        fault       = state_q == S_FAULT;
        fault_code  = code_q;
        depth       = depth_q;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues expected handoffs,
// a negedge monitor pops and compares them.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] pc_out;
    logic [18:0] mem_instr;
    logic [18:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        flag_z;
    logic        flag_c;
    logic        flags_valid;
    logic        fault;
    logic [1:0]  fault_code;
    logic [3:0]  depth;

    logic [18:0] mem [0:4095];
    logic [30:0] sb [$];
    logic [30:0] sb_e;
    int checks = 0;
    int errors = 0;

    fetch_sequencer #(.RESET_PC(12'h000), .STACK_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .pc_out(pc_out),
        .mem_instr(mem_instr), .instr_out(instr_out),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .flag_z(flag_z), .flag_c(flag_c), .flags_valid(flags_valid),
        .fault(fault), .fault_code(fault_code), .depth(depth)
    );

    assign mem_instr = mem[pc_out];

    always #5 clk = ~clk;

    function automatic logic [18:0] f_seq(input logic [11:0] a);
        return {7'd0, a};
    endfunction
    function automatic logic [18:0] f_jmp(input logic [11:0] t);
        return {5'b11100, 2'b00, t};
    endfunction
    function automatic logic [18:0] f_jsb(input logic [11:0] t);
        return {5'b11101, 2'b00, t};
    endfunction
    function automatic logic [18:0] f_ret();
        return {6'b111100, 13'd0};
    endfunction
    function automatic logic [18:0] f_br(input logic [1:0] c, input logic [7:0] o);
        return {3'b101, c, 6'd0, o};
    endfunction

    task automatic clear_mem();
        for (int a = 0; a < 4096; a++) mem[a] = f_seq(12'(a));
    endtask

    task automatic push_exp(input logic [11:0] p);
        sb.push_back({p, mem[p]});
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Handoff monitor: values seen at negedge are the ones taken at the next rising edge
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_handoff: got pc %0h expected none", pc_out);
            end else begin
                sb_e = sb.pop_front();
                if ({pc_out, instr_out} !== sb_e) begin
                    errors++;
                    $display("FAIL handoff: got pc %0h instr %0h expected pc %0h instr %0h",
                             pc_out, instr_out, sb_e[30:19], sb_e[18:0]);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after n handoffs
    task automatic run(input int n);
        int cnt = 0;
        int guard = 0;
        instr_ready = 1'b1;
        while (cnt < n && guard < 100) begin
            @(negedge clk);
            if (instr_valid && instr_ready) cnt++;
            guard++;
            @(posedge clk); #1;
        end
        instr_ready = 1'b0;
        chk("run_handoffs", cnt, n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic start_fetch();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic branch_wait(input logic z, input logic c);
        repeat (2) begin
            @(negedge clk);
            chk("br_bubble", instr_valid, 0);
            @(posedge clk); #1;
        end
        flags_valid = 1'b1;
        flag_z = z;
        flag_c = c;
        @(posedge clk); #1;
        flags_valid = 1'b0;
    endtask

    initial begin
        clk = 0; rst = 1; start = 0; instr_ready = 0;
        flag_z = 0; flag_c = 0; flags_valid = 0;
        clear_mem();
        @(posedge clk); #1;
        chk("rst_pc", pc_out, 12'h000);
        chk("rst_valid", instr_valid, 0);
        chk("rst_depth", depth, 0);
        chk("rst_fault", fault, 0);
        chk("rst_code", fault_code, 0);
        rst = 0;
        @(posedge clk); #1;
        chk("idle_no_start", instr_valid, 0);

        // straight line then backpressure at pc 5
        start_fetch();
        for (int i = 0; i < 5; i++) push_exp(12'(i));
        run(5);
        repeat (3) begin
            @(negedge clk);
            chk("bp_pc", pc_out, 12'd5);
            chk("bp_instr", instr_out, f_seq(12'd5));
            @(posedge clk); #1;
        end
        push_exp(12'd5);
        run(1);
        chk("bp_next_pc", pc_out, 12'd6);
        push_exp(12'd6);
        run(1);

        // BR Z +5 at pc 4, taken
        do_reset();
        clear_mem();
        mem[4] = f_br(2'b00, 8'h05);
        start_fetch();
        for (int i = 0; i < 5; i++) push_exp(12'(i));
        run(5);
        branch_wait(1'b1, 1'b0);
        chk("br_z_taken_pc", pc_out, 12'd10);
        push_exp(12'd10);
        run(1);

        // BR Z +5 at pc 4, not taken
        do_reset();
        start_fetch();
        for (int i = 0; i < 5; i++) push_exp(12'(i));
        run(5);
        branch_wait(1'b0, 1'b1);
        chk("br_z_fall_pc", pc_out, 12'd5);
        push_exp(12'd5);
        run(1);

        // BR NC -2 at pc 3 with C=0
        do_reset();
        clear_mem();
        mem[3] = f_br(2'b11, 8'hFE);
        start_fetch();
        for (int i = 0; i < 4; i++) push_exp(12'(i));
        run(4);
        branch_wait(1'b1, 1'b0);
        chk("br_nc_pc", pc_out, 12'd2);
        push_exp(12'd2);
        run(1);

        // subroutine call and return
        do_reset();
        clear_mem();
        mem[0]  = f_jmp(12'd40);
        mem[40] = f_jsb(12'd45);
        mem[45] = f_ret();
        start_fetch();
        push_exp(12'd0);
        push_exp(12'd40);
        run(2);
        chk("jsb_pc", pc_out, 12'd45);
        chk("jsb_depth", depth, 1);
        push_exp(12'd45);
        push_exp(12'd41);
        run(2);
        chk("ret_depth", depth, 0);
        chk("ret_pc", pc_out, 12'd42);

        // stack overflow on ninth nested call
        do_reset();
        clear_mem();
        for (int k = 0; k < 9; k++) mem[k] = f_jsb(12'(k + 1));
        start_fetch();
        for (int k = 0; k < 9; k++) push_exp(12'(k));
        run(9);
        chk("ovf_fault", fault, 1);
        chk("ovf_code", fault_code, 2'b01);
        chk("ovf_valid", instr_valid, 0);
        chk("ovf_depth", depth, 8);
        instr_ready = 1'b1;
        start = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        instr_ready = 1'b0;
        start = 1'b0;
        chk("fault_sticky", fault, 1);
        chk("fault_no_issue", instr_valid, 0);
        chk("fault_pc", pc_out, 12'd8);

        // underflow
        do_reset();
        chk("post_rst_fault", fault, 0);
        clear_mem();
        mem[0] = f_ret();
        start_fetch();
        push_exp(12'd0);
        run(1);
        chk("udf_fault", fault, 1);
        chk("udf_code", fault_code, 2'b10);
        chk("udf_depth", depth, 0);

        // wrap 4095 -> 0
        do_reset();
        clear_mem();
        mem[0] = f_jmp(12'hFFF);
        start_fetch();
        push_exp(12'h000);
        push_exp(12'hFFF);
        push_exp(12'h000);
        run(3);
        chk("wrap_pc", pc_out, 12'hFFF);

        // asynchronous reset during BR_WAIT with a stacked return
        do_reset();
        clear_mem();
        mem[0] = f_jsb(12'd5);
        mem[5] = f_br(2'b00, 8'h05);
        start_fetch();
        push_exp(12'd0);
        push_exp(12'd5);
        run(2);
        chk("brw_depth", depth, 1);
        chk("brw_valid", instr_valid, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_pc", pc_out, 12'd0);
        chk("async_depth", depth, 0);
        chk("async_valid", instr_valid, 0);
        chk("async_fault", fault, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        instr_ready = 1'b1;
        flags_valid = 1'b1;
        flag_z = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("no_restart_valid", instr_valid, 0);
        chk("no_restart_pc", pc_out, 12'd0);
        instr_ready = 1'b0;
        flags_valid = 1'b0;

        @(posedge clk); #1;
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
